legv8_multicycle_core: RTL and testbench
========================================

# legv8_multicycle_core

Parametrised multi-cycle LEGv8 core that replaces the single-cycle datapath in the CPU subsystem. Instruction and data memories are reached through request/acknowledge ports, so memories with wait states are supported. The core adds ADDI, SUBI and CBNZ, a halt on illegal opcode, and a retired-instruction counter. The 32-entry register file is internal, with X31 reading as zero (XZR).

## Interface
- DATA_W, 64: register, ALU, PC and address width; legal range 32..64.
- PC_RESET, 0: PC value loaded on reset; must be a multiple of 4.
- CNT_W, 32: width of the retired-instruction counter.

- CLOCK  in  1  rising-edge clock.
- RESET_N  in  1  reset; asynchronous assert, active-low.
- IMEM_REQ  out  1  instruction fetch request.
- IMEM_ADDR  out  DATA_W  fetch address, equal to PC.
- IMEM_ACK  in  1  fetch complete; IMEM_RDATA is valid in the same cycle.
- IMEM_RDATA  in  32  instruction word.
- DMEM_REQ  out  1  data access request.
- DMEM_WE  out  1  1 = store, 0 = load.
- DMEM_ADDR  out  DATA_W  data address.
- DMEM_WDATA  out  DATA_W  store data.
- DMEM_ACK  in  1  access complete; DMEM_RDATA is valid in the same cycle for a load.
- DMEM_RDATA  in  DATA_W  load data.
- PC  out  DATA_W  address of the current instruction.
- HALTED  out  1  core has stopped on an illegal opcode.
- RETIRED  out  CNT_W  count of completed instructions.

## Operation
- Supported formats and opcodes:
  - R-format, 11-bit opcode: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - D-format, 11-bit opcode: LDUR 11111000010, STUR 11111000000.
  - I-format, 10-bit opcode: ADDI 1001000100, SUBI 1101000100.
  - B-format, 6-bit opcode: B 000101.
  - CB-format, 8-bit opcode: CBZ 10110100, CBNZ 10110101.
- Instruction fields: Rd/Rt = [4:0], Rn = [9:5], Rm = [20:16].
- Immediates:
  - D-format offset = sign-extended [20:12].
  - I-format immediate = zero-extended [21:10].
  - B-format offset = sign-extended [25:0] << 2.
  - CB-format offset = sign-extended [23:5] << 2.
- All arithmetic is modulo 2^DATA_W; carry out and overflow are discarded.
- Branch target = PC + offset, where PC is the address of the branch instruction.
- CBZ and CBNZ test register Rt, which is read through the second register port.
- Register writes to X31 are discarded; reads of X31 return 0.
- FSM states and transitions:
  - FETCH: assert IMEM_REQ with IMEM_ADDR = PC. On IMEM_ACK, latch IR and go to DECODE.
  - DECODE: read the register operands. An illegal opcode goes to HALT.
  - EXECUTE:
    - ALU instructions go to WB.
    - LDUR/STUR compute the address and go to MEM.
    - B loads the target into PC and goes to FETCH.
    - CBZ/CBNZ load either the target or PC+4 into PC and go to FETCH.
    - Branches retire in EXECUTE.
  - MEM: hold DMEM_REQ, DMEM_WE, DMEM_ADDR and DMEM_WDATA stable until DMEM_ACK.
    - Load: latch the data and go to WB.
    - Store: set PC += 4, retire, and go to FETCH.
  - WB: write Rd, set PC += 4, retire, and go to FETCH.
  - HALT: terminal. HALTED = 1, no requests are issued, PC is frozen. Only reset exits.
- RETIRED increments by one in each retiring cycle and wraps at 2^CNT_W.
- An ACK received while the matching REQ is low is ignored.

## Timing
- Reset values:
  - PC = PC_RESET, state = FETCH, HALTED = 0, RETIRED = 0.
  - IMEM_REQ = DMEM_REQ = DMEM_WE = 0.
  - DMEM_ADDR = DMEM_WDATA = 0.
  - All registers = 0.
- IMEM_REQ rises in the first cycle after RESET_N deasserts.
- Minimum cycles per instruction, with ACK in the same cycle as REQ:
  - R-type and I-type: 4.
  - LDUR: 5.
  - STUR: 4.
  - B, CBZ, CBNZ: 3.
- Each memory wait cycle adds exactly one cycle.
- REQ stays high continuously until the ACK cycle and drops in the following cycle. No back-to-back request in the same state.
- The register write in WB is visible to the DECODE of the next instruction.
- RESET_N asserted mid-access forces REQ low immediately (asynchronously). The interrupted store has an undefined memory effect. RETIRED is not incremented.
- IR holds its value from the FETCH acknowledge until the next FETCH acknowledge.

## Structure
- Package legv8_pkg holds:
  - opcode constants;
  - the state enum {FETCH, DECODE, EXECUTE, MEM, WB, HALT};
  - ALU operation codes {ADD, SUB, AND, ORR, PASSB}.
- Sub-module legv8_regfile, parametrised by DATA_W:
  - 2 asynchronous read ports, 1 synchronous write port;
  - X31 hardwired to zero;
  - asynchronous active-low clear.
- ALU and immediate decode are written inline in the core.

## Test plan
- Reset, then ADDI X1,XZR,#5 followed by ADDI X2,X1,#7 with zero-wait memory -> X2 = 12, RETIRED = 2 after 8 cycles, PC = 8.
- STUR X2,[X1,#3] with DMEM_ACK delayed 3 cycles -> DMEM_ADDR = 8, DMEM_WDATA = 12, DMEM_WE = 1, all held for 4 cycles; the instruction takes 7 cycles. A subsequent LDUR X3,[X1,#3] returning 12 -> X3 = 12.
- CBZ X4,#-2 with X4 = 0 at PC = 0x20 -> PC = 0x18 after 3 cycles. The same instruction with X4 = 1 -> PC = 0x24. CBNZ gives the inverse results.
- SUB X5,XZR,X1 with X1 = 1 -> X5 = all ones. ADD XZR,X1,X1 -> X31 still reads 0.
- Illegal word 0x00000000 -> HALTED = 1 after DECODE; no further IMEM_REQ; RETIRED unchanged.
- RESET_N pulsed low while DMEM_REQ = 1 -> DMEM_REQ = 0 within the same cycle; PC = PC_RESET; RETIRED = 0; fetching restarts cleanly.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: opcode encodings, FSM states, ALU operations
// and a compact instruction classifier used by the multi-cycle core.
package legv8_pkg;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [4:0]  XZR     = 5'd31;

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT} state_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_PASSB} alu_op_t;
  typedef enum logic [2:0] {CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BR, CLS_CBR, CLS_ILLEGAL} iclass_t;

  typedef struct packed {
    iclass_t cls;
    alu_op_t alu_op;
    logic    use_imm;
    logic    cb_nz;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d.cls     = CLS_ILLEGAL;
    d.alu_op  = ALU_PASSB;
    d.use_imm = 1'b0;
    d.cb_nz   = 1'b0;
    if (ir[31:21] == OP_ADD) begin
      d.cls = CLS_ALU; d.alu_op = ALU_ADD;
    end else if (ir[31:21] == OP_SUB) begin
      d.cls = CLS_ALU; d.alu_op = ALU_SUB;
    end else if (ir[31:21] == OP_AND) begin
      d.cls = CLS_ALU; d.alu_op = ALU_AND;
    end else if (ir[31:21] == OP_ORR) begin
      d.cls = CLS_ALU; d.alu_op = ALU_ORR;
    end else if (ir[31:21] == OP_LDUR) begin
      d.cls = CLS_LOAD;
    end else if (ir[31:21] == OP_STUR) begin
      d.cls = CLS_STORE;
    end else if (ir[31:22] == OP_ADDI) begin
      d.cls = CLS_ALU; d.alu_op = ALU_ADD; d.use_imm = 1'b1;
    end else if (ir[31:22] == OP_SUBI) begin
      d.cls = CLS_ALU; d.alu_op = ALU_SUB; d.use_imm = 1'b1;
    end else if (ir[31:26] == OP_B) begin
      d.cls = CLS_BR;
    end else if (ir[31:24] == OP_CBZ) begin
      d.cls = CLS_CBR;
    end else if (ir[31:24] == OP_CBNZ) begin
      d.cls = CLS_CBR; d.cb_nz = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/legv8_regfile.sv
// 32 x DATA_W register file: two asynchronous read ports, one synchronous
// write port, X31 reads as zero and ignores writes.
module legv8_regfile
  import legv8_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        ra1,
  input  logic [4:0]        ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs_q [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we && (wa != XZR)) begin
      regs_q[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = (ra1 == XZR) ? '0 : regs_q[ra1];
    rd2 = (ra2 == XZR) ? '0 : regs_q[ra2];
  end

endmodule

// File: rtl/legv8_multicycle_core.sv
// Multi-cycle LEGv8 core with request/acknowledge instruction and data
// ports, internal register file, halt on illegal opcode and retire counter.
module legv8_multicycle_core
  import legv8_pkg::*;
#(
  parameter int unsigned       DATA_W   = 64,
  parameter logic [DATA_W-1:0] PC_RESET = '0,
  parameter int unsigned       CNT_W    = 32
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  output logic              IMEM_REQ,
  output logic [DATA_W-1:0] IMEM_ADDR,
  input  logic              IMEM_ACK,
  input  logic [31:0]       IMEM_RDATA,
  output logic              DMEM_REQ,
  output logic              DMEM_WE,
  output logic [DATA_W-1:0] DMEM_ADDR,
  output logic [DATA_W-1:0] DMEM_WDATA,
  input  logic              DMEM_ACK,
  input  logic [DATA_W-1:0] DMEM_RDATA,
  output logic [DATA_W-1:0] PC,
  output logic              HALTED,
  output logic [CNT_W-1:0]  RETIRED
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, res_q, res_d;
  logic [DATA_W-1:0] daddr_q, daddr_d, wdata_q, wdata_d;
  logic [31:0]       ir_q, ir_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  dec_t              dec;
  logic [4:0]        ra2;
  logic [DATA_W-1:0] rd1, rd2, imm_d, imm_i, imm_b, imm_cb, opb, alu_y, pc_plus4;
  logic              retire, rf_we, cb_taken;

  legv8_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk  (CLOCK),
    .rst_n(RESET_N),
    .ra1  (ir_q[9:5]),
    .ra2  (ra2),
    .rd1  (rd1),
    .rd2  (rd2),
    .we   (rf_we),
    .wa   (ir_q[4:0]),
    .wd   (res_q)
  );

  always_comb begin
    dec      = decode(ir_q);
    // Second port reads Rm for register ALU ops, Rt for stores and CBZ/CBNZ
    ra2      = (dec.cls == CLS_ALU && !dec.use_imm) ? ir_q[20:16] : ir_q[4:0];
    imm_d    = {{(DATA_W-9){ir_q[20]}}, ir_q[20:12]};
    imm_i    = {{(DATA_W-12){1'b0}}, ir_q[21:10]};
    imm_b    = {{(DATA_W-28){ir_q[25]}}, ir_q[25:0], 2'b00};
    imm_cb   = {{(DATA_W-21){ir_q[23]}}, ir_q[23:5], 2'b00};
    pc_plus4 = pc_q + DATA_W'(4);
    opb      = dec.use_imm ? imm_i : b_q;
    cb_taken = (b_q == '0) ^ dec.cb_nz;
    case (dec.alu_op)
      ALU_ADD: alu_y = a_q + opb;
      ALU_SUB: alu_y = a_q - opb;
      ALU_AND: alu_y = a_q & opb;
      ALU_ORR: alu_y = a_q | opb;
      default: alu_y = opb;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    daddr_d = daddr_q;
    wdata_d = wdata_q;
    retire  = 1'b0;
    rf_we   = 1'b0;
    case (state_q)
      FETCH: if (IMEM_ACK) begin
        ir_d    = IMEM_RDATA;
        state_d = DECODE;
      end
      DECODE: begin
        a_d     = rd1;
        b_d     = rd2;
        state_d = (dec.cls == CLS_ILLEGAL) ? HALT : EXECUTE;
      end
      EXECUTE: case (dec.cls)
        CLS_ALU: begin
          res_d   = alu_y;
          state_d = WB;
        end
        CLS_LOAD, CLS_STORE: begin
          daddr_d = a_q + imm_d;
          wdata_d = b_q;
          state_d = MEM;
        end
        CLS_BR: begin
          pc_d    = pc_q + imm_b;
          retire  = 1'b1;
          state_d = FETCH;
        end
        CLS_CBR: begin
          pc_d    = cb_taken ? (pc_q + imm_cb) : pc_plus4;
          retire  = 1'b1;
          state_d = FETCH;
        end
        default: state_d = HALT;
      endcase
      MEM: if (DMEM_ACK) begin
        if (dec.cls == CLS_STORE) begin
          pc_d    = pc_plus4;
          retire  = 1'b1;
          state_d = FETCH;
        end else begin
          res_d   = DMEM_RDATA;
          state_d = WB;
        end
      end
      WB: begin
        rf_we   = 1'b1;
        pc_d    = pc_plus4;
        retire  = 1'b1;
        state_d = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
    retired_d = retired_q + CNT_W'(retire);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= FETCH;
      pc_q      <= PC_RESET;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      daddr_q   <= '0;
      wdata_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      daddr_q   <= daddr_d;
      wdata_q   <= wdata_d;
      retired_q <= retired_d;
    end
  end

  // State resets to FETCH, so requests are gated by RESET_N to stay low in reset
  always_comb begin
    IMEM_REQ   = RESET_N && (state_q == FETCH);
    IMEM_ADDR  = pc_q;
    DMEM_REQ   = RESET_N && (state_q == MEM);
    DMEM_WE    = DMEM_REQ && (dec.cls == CLS_STORE);
    DMEM_ADDR  = daddr_q;
    DMEM_WDATA = wdata_q;
    PC         = pc_q;
    HALTED     = (state_q == HALT);
    RETIRED    = retired_q;
  end

endmodule

// File: tb/tb_legv8_multicycle_core.sv
// Scoreboard bench for legv8_multicycle_core: directed programs, memory
// models with wait states, fetch/data monitors checking queued expectations.
module tb_legv8_multicycle_core;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        IMEM_REQ, DMEM_REQ, DMEM_WE, HALTED;
  logic [63:0] IMEM_ADDR, DMEM_ADDR, DMEM_WDATA, PC;
  logic        IMEM_ACK = 1'b0, DMEM_ACK = 1'b0;
  logic [31:0] IMEM_RDATA = '0;
  logic [63:0] DMEM_RDATA = '0;
  logic [31:0] RETIRED;

  legv8_multicycle_core #(.DATA_W(64), .PC_RESET(64'h0), .CNT_W(32)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
    .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA),
    .PC(PC), .HALTED(HALTED), .RETIRED(RETIRED)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {logic [63:0] addr; int delta;} fexp_t;
  typedef struct {logic we; logic [63:0] addr; logic [63:0] wdata; int len;} dexp_t;

  fexp_t       fq[$];
  dexp_t       dq[$];
  int          dwq[$];
  logic [31:0] imem [0:63];
  logic [63:0] dmem [0:15];
  int unsigned imem_wait = 0;
  int          n_cmp = 0, n_bad = 0;
  longint      cyc = 0;

  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic pf(input logic [63:0] a, input int d);
    fexp_t e;
    e.addr = a; e.delta = d;
    fq.push_back(e);
  endtask

  task automatic pd(input logic we, input logic [63:0] a, input logic [63:0] w, input int len);
    dexp_t e;
    e.we = we; e.addr = a; e.wdata = w; e.len = len;
    dq.push_back(e);
  endtask

  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm, rn, rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction
  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] off, input logic [4:0] rn, rt);
    return {op, off, 2'b00, rn, rt};
  endfunction
  function automatic logic [31:0] enc_i(input logic [9:0] op, input logic [11:0] imm, input logic [4:0] rn, rd);
    return {op, imm, rn, rd};
  endfunction
  function automatic logic [31:0] enc_b(input logic [25:0] off);
    return {6'b000101, off};
  endfunction
  function automatic logic [31:0] enc_cb(input logic [7:0] op, input logic [18:0] off, input logic [4:0] rt);
    return {op, off, rt};
  endfunction

  // Memory models: ACK decided at the falling edge for the coming rising edge
  int unsigned icnt = 0, dcnt = 0;
  int          cur_dw = 0;
  logic        d_busy = 1'b0;
  always @(negedge CLOCK) begin
    if (IMEM_REQ) begin
      if (icnt >= imem_wait) begin
        IMEM_ACK = 1'b1; IMEM_RDATA = imem[IMEM_ADDR[7:2]]; icnt = 0;
      end else begin
        IMEM_ACK = 1'b0; icnt++;
      end
    end else begin
      IMEM_ACK = 1'b0; icnt = 0;
    end
    if (DMEM_REQ) begin
      if (!d_busy) begin
        d_busy = 1'b1; dcnt = 0; cur_dw = 0;
        if (dwq.size() > 0) cur_dw = dwq.pop_front();
      end
      if (dcnt >= cur_dw) begin
        DMEM_ACK = 1'b1; d_busy = 1'b0;
        if (DMEM_WE) dmem[DMEM_ADDR[6:3]] = DMEM_WDATA;
        else DMEM_RDATA = dmem[DMEM_ADDR[6:3]];
      end else begin
        DMEM_ACK = 1'b0; dcnt++;
      end
    end else begin
      DMEM_ACK = 1'b0; d_busy = 1'b0;
    end
  end

  longint last_fetch = 0;
  always @(negedge CLOCK) begin
    fexp_t e;
    #1;
    if (IMEM_REQ && IMEM_ACK) begin
      if (fq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL fetch_unexpected: actual addr %h required no fetch", IMEM_ADDR);
      end else begin
        e = fq.pop_front();
        check("fetch_addr", IMEM_ADDR, e.addr);
        if (e.delta >= 0) check("fetch_interval", 64'(cyc - last_fetch), 64'(e.delta));
      end
      last_fetch = cyc;
    end
  end

  logic        d_prev = 1'b0, d_we_s;
  logic [63:0] d_addr_s, d_wdata_s;
  int          d_len = 0;
  always @(negedge CLOCK) begin
    dexp_t e;
    #1;
    if (DMEM_REQ) begin
      if (!d_prev) begin
        d_we_s = DMEM_WE; d_addr_s = DMEM_ADDR; d_wdata_s = DMEM_WDATA; d_len = 1;
      end else begin
        d_len++;
        check("dmem_hold_we", 64'(DMEM_WE), 64'(d_we_s));
        check("dmem_hold_addr", DMEM_ADDR, d_addr_s);
        check("dmem_hold_wdata", DMEM_WDATA, d_wdata_s);
      end
      if (DMEM_ACK) begin
        if (dq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL dmem_unexpected: actual addr %h required no access", DMEM_ADDR);
        end else begin
          e = dq.pop_front();
          check("dmem_we", 64'(DMEM_WE), 64'(e.we));
          check("dmem_addr", DMEM_ADDR, e.addr);
          if (e.we) check("dmem_wdata", DMEM_WDATA, e.wdata);
          check("dmem_req_cycles", 64'(d_len), 64'(e.len));
        end
      end
    end
    d_prev = DMEM_REQ && !DMEM_ACK;
  end

  task automatic do_reset();
    @(posedge CLOCK); #2;
    RESET_N = 1'b0;
    repeat (2) @(posedge CLOCK);
    #2;
    check("rst_pc", PC, 64'h0);
    check("rst_halted", 64'(HALTED), 64'd0);
    check("rst_retired", 64'(RETIRED), 64'd0);
    check("rst_imem_req", 64'(IMEM_REQ), 64'd0);
    check("rst_dmem_req", 64'(DMEM_REQ | DMEM_WE), 64'd0);
  endtask

  task automatic wait_halt(input int budget);
    int i;
    i = 0;
    while (!HALTED && i < budget) begin
      @(negedge CLOCK); i++;
    end
    #1;
    check("halt_reached", 64'(HALTED), 64'd1);
  endtask

  task automatic post_halt(input logic [63:0] exp_pc, input logic [31:0] exp_ret);
    int reqs;
    reqs = 0;
    check("fetch_queue_drained", 64'(fq.size()), 64'd0);
    check("dmem_queue_drained", 64'(dq.size()), 64'd0);
    repeat (10) begin
      @(negedge CLOCK); #1;
      if (IMEM_REQ || DMEM_REQ) reqs++;
    end
    check("no_req_after_halt", 64'(reqs), 64'd0);
    check("halt_pc", PC, exp_pc);
    check("halt_retired", 64'(RETIRED), 64'(exp_ret));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    #1 RESET_N = 1'b0;
    // Program A: ALU ops, waited store, load-back, XZR, illegal halt
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    imem[0]  = enc_i(10'b1001000100, 12'd5, 5'd31, 5'd1);
    imem[1]  = enc_i(10'b1001000100, 12'd7, 5'd1, 5'd2);
    imem[2]  = enc_d(11'b11111000000, 9'd3, 5'd1, 5'd2);
    imem[3]  = enc_d(11'b11111000010, 9'd3, 5'd1, 5'd3);
    imem[4]  = enc_d(11'b11111000000, 9'd16, 5'd31, 5'd3);
    imem[5]  = enc_i(10'b1001000100, 12'd1, 5'd31, 5'd1);
    imem[6]  = enc_r(11'b11001011000, 5'd1, 5'd31, 5'd5);
    imem[7]  = enc_d(11'b11111000000, 9'd24, 5'd31, 5'd5);
    imem[8]  = enc_r(11'b10001011000, 5'd1, 5'd1, 5'd31);
    imem[9]  = enc_d(11'b11111000000, 9'd32, 5'd31, 5'd31);
    imem[10] = enc_r(11'b10001010000, 5'd2, 5'd5, 5'd6);
    imem[11] = enc_r(11'b10101010000, 5'd1, 5'd6, 5'd7);
    imem[12] = enc_d(11'b11111000000, 9'd40, 5'd31, 5'd7);
    do_reset();
    pf(64'h00, -1); pf(64'h04, 4); pf(64'h08, 4); pf(64'h0C, 7); pf(64'h10, 5);
    pf(64'h14, 4);  pf(64'h18, 4); pf(64'h1C, 4); pf(64'h20, 4); pf(64'h24, 4);
    pf(64'h28, 4);  pf(64'h2C, 4); pf(64'h30, 4); pf(64'h34, 4);
    pd(1'b1, 64'd8, 64'd12, 4);  pd(1'b0, 64'd8, 64'd0, 1);   pd(1'b1, 64'd16, 64'd12, 1);
    pd(1'b1, 64'd24, '1, 1);     pd(1'b1, 64'd32, 64'd0, 1);  pd(1'b1, 64'd40, 64'd13, 1);
    dwq.push_back(3);
    RESET_N = 1'b1;
    repeat (8) @(posedge CLOCK);
    #2;
    check("a_retired_8cyc", 64'(RETIRED), 64'd2);
    check("a_pc_8cyc", PC, 64'h8);
    wait_halt(300);
    post_halt(64'h34, 32'd13);

    // Program B: B/CBZ/CBNZ both ways, SUBI, one fetch wait state
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    imem[0]  = enc_b(26'd8);
    imem[6]  = enc_i(10'b1001000100, 12'd1, 5'd31, 5'd4);
    imem[7]  = enc_b(26'd1);
    imem[8]  = enc_cb(8'b10110100, 19'h7FFFE, 5'd4);
    imem[9]  = enc_cb(8'b10110101, 19'd2, 5'd4);
    imem[11] = enc_i(10'b1101000100, 12'd1, 5'd4, 5'd4);
    imem[12] = enc_cb(8'b10110101, 19'h7FFFE, 5'd4);
    imem_wait = 1;
    do_reset();
    pf(64'h00, -1); pf(64'h20, 4); pf(64'h18, 4); pf(64'h1C, 5); pf(64'h20, 4);
    pf(64'h24, 4);  pf(64'h2C, 4); pf(64'h30, 5); pf(64'h34, 4);
    RESET_N = 1'b1;
    wait_halt(300);
    post_halt(64'h34, 32'd8);

    // Program C: reset asserted while a store is waiting for DMEM_ACK
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    imem[0] = enc_i(10'b1001000100, 12'd5, 5'd31, 5'd1);
    imem[1] = enc_d(11'b11111000000, 9'd8, 5'd31, 5'd1);
    imem_wait = 0;
    do_reset();
    pf(64'h00, -1); pf(64'h04, 4);
    dwq.push_back(1000);
    dwq.push_back(0);
    RESET_N = 1'b1;
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      @(negedge CLOCK); #1;
      if (DMEM_REQ) found = 1;
    end
    check("c_store_issued", 64'(found), 64'd1);
    check("c_retired_before", 64'(RETIRED), 64'd1);
    @(posedge CLOCK); #3;
    RESET_N = 1'b0;
    #1;
    check("c_dmem_req_async", 64'(DMEM_REQ), 64'd0);
    check("c_dmem_we_async", 64'(DMEM_WE), 64'd0);
    check("c_dmem_addr_rst", DMEM_ADDR, 64'd0);
    check("c_dmem_wdata_rst", DMEM_WDATA, 64'd0);
    check("c_pc_rst", PC, 64'h0);
    check("c_retired_rst", 64'(RETIRED), 64'd0);
    check("c_imem_req_rst", 64'(IMEM_REQ), 64'd0);
    pf(64'h00, -1); pf(64'h04, 4); pf(64'h08, 4);
    pd(1'b1, 64'd8, 64'd5, 1);
    repeat (2) @(posedge CLOCK);
    #2 RESET_N = 1'b1;
    wait_halt(200);
    post_halt(64'h08, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
